// File: rtl/register_seq_ctrl.sv
// register_seq_ctrl: store sequencer for the register bank.
// A start request launches a burst of single-cycle row writes to consecutive
// (wrapping) row addresses from a latched base, for a latched row count, with
// write data chosen by a latched data mode. Abort, busy and zero-length
// requests are handled.
//
// Handshake: start is sampled only in IDLE (dropped, not queued, otherwise).
// abort is sampled only in WRITE; the write shown in the sampling cycle still
// completes. done / aborted are single-cycle pulses and are mutually exclusive.
//
// Optional build macro REG_SEQ_WAIT_EN: adds a mem_ready input. While
// mem_ready is low in WRITE, the current write (address, data, strobe) and the
// index are held; a row only counts in a cycle where mem_ready is high.
// Abort is still honoured while stalled.
module register_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  row_count,
  input  logic [1:0]        data_mode,
  input  logic [DATA_W-1:0] data_in,
`ifdef REG_SEQ_WAIT_EN
  input  logic              mem_ready,
`endif
  output logic [ADDR_W-1:0] rowaddr,
  output logic [DATA_W-1:0] wr_data,
  output logic              writemem,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   base_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   data_q;
  logic                load;
  logic                advance;
  logic [ADDR_W-1:0]   cur_addr;

`ifdef REG_SEQ_WAIT_EN
  assign advance = mem_ready;
`else
  assign advance = 1'b1;
`endif

  // State, index and burst-parameter registers; parameters latch on accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      mode_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        cnt_q  <= row_count;
        base_q <= base_addr;
        mode_q <= data_mode;
        data_q <= data_in;
      end
    end
  end

  // Next-state and index update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start && !abort) begin
          load = 1'b1;
          if (row_count == '0) state_d = S_DONE;
          else                 state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_ABORT;
          idx_d   = '0;
        end else if (advance) begin
          if (idx_q == cnt_q - CNT_W'(1)) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      S_ABORT: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign cur_addr = base_q + ADDR_W'(idx_q);

  // Outputs decode straight from the state so an async reset clears them at once.
  always_comb begin
    writemem = 1'b0;
    rowaddr  = '0;
    wr_data  = '0;
    if (state_q == S_WRITE) begin
      writemem = 1'b1;
      rowaddr  = cur_addr;
      case (mode_q)
        2'd1:    wr_data = data_q;
        2'd2:    wr_data = data_q + DATA_W'(idx_q);
        default: wr_data = DATA_W'(cur_addr);
      endcase
    end
  end

  assign busy      = (state_q == S_WRITE) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign aborted   = (state_q == S_ABORT);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_register_seq_ctrl.sv
// Directed bench for register_seq_ctrl. Inputs change on the falling edge,
// outputs are checked on the falling edge (mid-cycle). Observed output
// vector: {rowaddr[3:0], wr_data[15:0], writemem, busy, done, aborted}.
module tb_register_seq_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        abort;
  logic [3:0]  base_addr;
  logic [3:0]  row_count;
  logic [1:0]  data_mode;
  logic [15:0] data_in;
  logic        mem_ready;
  logic [3:0]  rowaddr;
  logic [15:0] wr_data;
  logic        writemem;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [1:0]  fsm_state;

  int checks;
  int errors;

  logic [23:0] obs;
  logic [23:0] exp_v;

  register_seq_ctrl #(.ADDR_W(4), .DATA_W(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .row_count (row_count),
    .data_mode (data_mode),
    .data_in   (data_in),
`ifdef REG_SEQ_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .rowaddr   (rowaddr),
    .wr_data   (wr_data),
    .writemem  (writemem),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {rowaddr, wr_data, writemem, busy, done, aborted};

  // Drive one start pulse; returns at the falling edge of cycle 1.
  task automatic pulse_start(input logic [3:0] b, input logic [3:0] n,
                             input logic [1:0] m, input logic [15:0] d);
    @(negedge clk);
    base_addr = b;
    row_count = n;
    data_mode = m;
    data_in   = d;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 4'hF;
    row_count = 4'hF;
    data_mode = 2'd3;
    data_in   = 16'hFFFF;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #12;
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 24'h0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL idle_outputs got=%h want=%h", obs, 24'h0);
    end
  endtask

  task automatic test_legacy_burst;
    pulse_start(4'd8, 4'd4, 2'd0, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      exp_v = {4'(8 + i), 16'(8 + i), 1'b1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL legacy_write%0d got=%h want=%h", i, obs, exp_v);
      end
      @(negedge clk);
    end
    exp_v = {4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL legacy_done got=%h want=%h", obs, exp_v);
    end
    @(negedge clk);
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL legacy_idle got=%h want=%h", obs, 24'h0);
    end
  endtask

  task automatic test_wrap_incr;
    logic [3:0] addrs [4];
    addrs[0] = 4'd14; addrs[1] = 4'd15; addrs[2] = 4'd0; addrs[3] = 4'd1;
    pulse_start(4'd14, 4'd4, 2'd2, 16'h1000);
    for (int i = 0; i < 4; i++) begin
      exp_v = {addrs[i], 16'(16'h1000 + i), 1'b1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL wrap_write%0d got=%h want=%h", i, obs, exp_v);
      end
      @(negedge clk);
    end
    exp_v = {4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_done got=%h want=%h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_modes;
    // mode 1: constant data
    pulse_start(4'd3, 4'd2, 2'd1, 16'hBEEF);
    for (int i = 0; i < 2; i++) begin
      exp_v = {4'(3 + i), 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mode1_write%0d got=%h want=%h", i, obs, exp_v);
      end
      @(negedge clk);
    end
    @(negedge clk);
    // mode 3: behaves as mode 0
    pulse_start(4'd5, 4'd1, 2'd3, 16'hABCD);
    exp_v = {4'd5, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mode3_write got=%h want=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mode3_done got=%h want=%h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_length;
    pulse_start(4'd7, 4'd0, 2'd0, 16'h0);
    exp_v = {4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_len_done got=%h want=%h", obs, exp_v);
    end
    @(negedge clk);
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL zero_len_idle got=%h want=%h", obs, 24'h0);
    end
  endtask

  task automatic test_start_with_abort;
    @(negedge clk);
    base_addr = 4'd2;
    row_count = 4'd3;
    data_mode = 2'd0;
    start     = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (obs !== 24'h0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL start_abort_idle got=%h/%0d want=%h/0", obs, fsm_state, 24'h0);
    end
  endtask

  task automatic test_abort;
    int done_seen;
    done_seen = 0;
    pulse_start(4'd0, 4'd8, 2'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      exp_v = {4'(i), 16'(i), 1'b1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort_write%0d got=%h want=%h", i, obs, exp_v);
      end
      if (i == 1) start = 1'b1;   // start while busy: must be ignored
      if (i == 2) begin
        start = 1'b0;
        abort = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    exp_v = {4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_pulse got=%h want=%h", obs, exp_v);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || writemem || aborted) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_after got=%0d want=0", done_seen);
    end
  endtask

  task automatic test_reset_mid_burst;
    int pulses;
    pulses = 0;
    pulse_start(4'd8, 4'd8, 2'd0, 16'h0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_async got=%h want=%h", obs, 24'h0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done || aborted) pulses++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || aborted || writemem) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulses got=%0d want=0", pulses);
    end
  endtask

`ifdef REG_SEQ_WAIT_EN
  task automatic test_wait;
    mem_ready = 1'b0;
    pulse_start(4'd8, 4'd2, 2'd0, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      exp_v = {4'd8, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL wait_hold_c%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c == 4) mem_ready = 1'b1;
      @(negedge clk);
    end
    exp_v = {4'd9, 16'h0009, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wait_second got=%h want=%h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wait_done got=%h want=%h", obs, exp_v);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rstn      = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    row_count = '0;
    data_mode = '0;
    data_in   = '0;
    mem_ready = 1'b1;
    test_reset();
    test_legacy_burst();
    test_wrap_incr();
    test_modes();
    test_zero_length();
    test_start_with_abort();
    test_abort();
    test_reset_mid_burst();
`ifdef REG_SEQ_WAIT_EN
    test_wait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_seq_ctrl.md
Name: register_seq_ctrl

Overview:
Parametrised store sequencer for the register bank in the memory controller. On a start request it issues a burst of single-cycle row writes to consecutive row addresses, beginning at a programmable base and running for a programmable count. Write data comes from a selectable mode. The block replaces the fixed four-row (1000..1011) store controller and adds abort, busy and zero-length handling. It sits between the state controller (start/done handshake) and the register bank (rowaddr/writemem/data).

Parameters:
ADDR_W, 4, row address width; addresses wrap modulo 2^ADDR_W
DATA_W, 16, write data width
CNT_W, 4, width of row_count; maximum burst length is 2^CNT_W-1 rows

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, asynchronous, active-low
start  in  1  store request; sampled only in IDLE
abort  in  1  cancel an in-progress burst; sampled in WRITE
base_addr  in  ADDR_W  first row address; latched at start
row_count  in  CNT_W  number of rows to write; latched at start
data_mode  in  2  0=data equals row address zero-extended; 1=constant data_in; 2=data_in+index; 3=reserved, treated as 0
data_in  in  DATA_W  data operand; latched at start
rowaddr  out  ADDR_W  register-bank row address
wr_data  out  DATA_W  register-bank write data
writemem  out  1  write strobe; one row per cycle it is high
busy  out  1  high in WRITE and DONE
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort completion

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset value of all outputs is 0. State resets to IDLE and the index to 0. A reset asserted mid-burst clears all outputs at once, with no done or aborted pulse.
- States:
  - IDLE: outputs are 0.
  - WRITE: issues the writes.
  - DONE: one cycle.
  - ABORT: one cycle.
- IDLE to WRITE, on start=1, abort=0 and row_count!=0:
  - Latch base_addr, row_count, data_mode and data_in.
  - On the next cycle: writemem=1, rowaddr=base, index=0.
- IDLE with start=1 and row_count=0: go to DONE with no writemem pulse.
- IDLE with start=1 and abort=1: abort wins; start is ignored and the block stays in IDLE.
- WRITE, per cycle:
  - Write number i: rowaddr=(base+i) mod 2^ADDR_W.
  - wr_data in mode 0 is the zero-extended rowaddr. In mode 1 it is data_in. In mode 2 it is (data_in+i) mod 2^DATA_W.
  - The index increments every cycle.
  - After the write with i=count-1, go to DONE.
- Latency: for N>0, writes occupy cycles 1..N after start is sampled. done=1 and writemem=0 in cycle N+1, then IDLE in N+2. For N=0, done is in cycle 1.
- Abort sampled high in WRITE:
  - The write in that cycle still completes.
  - Next cycle: ABORT state, writemem=0, aborted=1, done=0. Then IDLE.
- start while busy is ignored; it is not queued.
- In DONE and ABORT, rowaddr and wr_data return to 0.
- done and aborted are never high together.

Optional Feature:
REG_SEQ_WAIT_EN:
- Defined:
  - Adds input mem_ready (1 bit).
  - In WRITE with mem_ready=0: rowaddr, wr_data, writemem=1 and the index are all held. The write counts only in a cycle where mem_ready=1.
  - Abort is still honoured while stalled.
- Undefined: no mem_ready port; one row is written every WRITE cycle.

Test Plan:
- Reset: rstn=0 at any time -> all outputs 0. Assert mid-burst -> writemem drops asynchronously, and neither done nor aborted pulses.
- Legacy-equivalent burst: base=8, count=4, mode=0 -> rowaddr 8,9,10,11 with wr_data 0x0008..0x000B in cycles 1-4, done=1 in cycle 5, busy high in cycles 1-5.
- Wrap and increment mode: base=14, count=4, mode=2, data_in=0x1000 -> rowaddr 14,15,0,1 with wr_data 0x1000..0x1003.
- Zero length: start with row_count=0 -> writemem never high, done=1 in cycle 1.
- Abort: base=0, count=8, abort=1 during the third write (rowaddr=2) -> the third write completes, aborted=1 next cycle, done never pulses. A start pulsed during the burst is ignored.
- WAIT_EN: mem_ready held 0 for 3 cycles on the first write (base=8) -> rowaddr stays 8 with writemem=1 for 4 cycles. Total completion is delayed by 3 cycles.
